// File: rtl/usb_uart_tx_arbiter.sv
// Round-robin, frame-locking arbiter that shares the usb_uart transmit byte pipeline among NUM_REQ requesters.
// Optional tag header per grant (8'hF0 | grant_idx) is enabled by defining USB_UART_TX_ARB_TAG_EN.
module usb_uart_tx_arbiter #(
  parameter int         NUM_REQ      = 4,
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_TIMEOUT = 255,
  parameter logic [7:0] TERM_BYTE    = 8'h0A
) (
  input  logic                       clk_48mhz,
  input  logic                       reset_n,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 uart_in_data,
  output logic                       uart_in_valid,
  input  logic                       uart_in_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       busy
);

  localparam int         IDX_W       = $clog2(NUM_REQ);
  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
  localparam logic [7:0] IDLE_LIMIT  = 8'(IDLE_TIMEOUT);

  // Handshakes on both sides: a byte moves on a cycle where valid and ready
  // are both high; a valid byte and its data stay stable until that cycle.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCK,
    ST_RELEASE
`ifdef USB_UART_TX_ARB_TAG_EN
    , ST_HEADER
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [7:0]       burst_q, burst_d;
  logic [7:0]       idle_q, idle_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             out_free;
  logic             sel_valid;
  logic [7:0]       sel_data;
  logic             accept;
  logic [7:0]       burst_inc;
  logic [7:0]       idle_inc;
  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;

  assign uart_in_data  = out_data_q;
  assign uart_in_valid = out_valid_q;
  assign grant_idx     = grant_q;
  assign busy          = (state_q != ST_IDLE);

  // The output register can take a new byte when empty or draining this cycle.
  assign out_free  = !out_valid_q || uart_in_ready;
  assign sel_valid = req_valid[grant_q];
  assign sel_data  = req_data[{grant_q, 3'b000} +: 8];
  assign accept    = (state_q == ST_LOCK) && sel_valid && out_free;

  assign burst_inc = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
  assign idle_inc  = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;

  always_comb begin
    req_ready = '0;
    if ((state_q == ST_LOCK) && out_free) begin
      req_ready = NUM_REQ'(1) << grant_q;
    end
  end

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int j;
    arb_found = 1'b0;
    arb_idx   = '0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (!arb_found && req_valid[IDX_W'(j)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    burst_d     = burst_q;
    idle_d      = idle_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && uart_in_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          burst_d = 8'd0;
          idle_d  = 8'd0;
`ifdef USB_UART_TX_ARB_TAG_EN
          // The output register is always empty in IDLE, so the header is loaded on the grant edge.
          out_data_d  = 8'hF0 | 8'(arb_idx);
          out_valid_d = 1'b1;
          state_d     = ST_HEADER;
`else
          state_d = ST_LOCK;
`endif
        end
      end
`ifdef USB_UART_TX_ARB_TAG_EN
      ST_HEADER: begin
        if (uart_in_ready) begin
          state_d = ST_LOCK;
        end
      end
`endif
      ST_LOCK: begin
        if (accept) begin
          out_data_d  = sel_data;
          out_valid_d = 1'b1;
          burst_d     = burst_inc;
          idle_d      = 8'd0;
          if ((sel_data == TERM_BYTE) || (burst_inc >= BURST_LIMIT)) begin
            state_d = ST_RELEASE;
          end
        end else if (!sel_valid) begin
          idle_d = idle_inc;
          if (idle_inc >= IDLE_LIMIT) begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        // Hold the grant until the frame's last byte has left the output register.
        if (out_free) begin
          state_d = ST_IDLE;
          rr_d    = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      burst_q     <= 8'd0;
      idle_q      <= 8'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      burst_q     <= burst_d;
      idle_q      <= idle_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_usb_uart_tx_arbiter.sv
// Scoreboard bench for usb_uart_tx_arbiter: per-requester byte sources, expected output queue, final report.
module tb_usb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int MAX_BURST    = 4;
  localparam int IDLE_TIMEOUT = 8;
`ifdef USB_UART_TX_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  // clock / reset
  logic clk_48mhz = 1'b0;
  logic reset_n;
  always #5 clk_48mhz = ~clk_48mhz;

  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           uart_in_data;
  logic                 uart_in_valid;
  logic                 uart_in_ready;
  logic [1:0]           grant_idx;
  logic                 busy;

  usb_uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .MAX_BURST(MAX_BURST),
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .TERM_BYTE(8'h0A)
  ) dut (
    .clk_48mhz(clk_48mhz),
    .reset_n(reset_n),
    .req_data(req_data),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .uart_in_data(uart_in_data),
    .uart_in_valid(uart_in_valid),
    .uart_in_ready(uart_in_ready),
    .grant_idx(grant_idx),
    .busy(busy)
  );

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] src_mem [NUM_REQ][32];
  int src_cnt [NUM_REQ];
  int src_ptr [NUM_REQ];
  int n_cmp = 0;
  int n_err = 0;
  int out_total = 0;

  logic               s_busy;
  logic               s_valid;
  logic [7:0]         s_data;
  logic [1:0]         s_grant;
  logic [NUM_REQ-1:0] s_rdy;
  logic [NUM_REQ-1:0] s_hs;
  logic               s_out_hs;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic src_clear();
    for (int r = 0; r < NUM_REQ; r++) begin
      src_cnt[r] = 0;
      src_ptr[r] = 0;
    end
  endtask

  task automatic src_add(input int r, input logic [7:0] b);
    src_mem[r][src_cnt[r]] = b;
    src_cnt[r]++;
  endtask

  task automatic drive_inputs();
    for (int r = 0; r < NUM_REQ; r++) begin
      if (src_ptr[r] < src_cnt[r]) begin
        req_valid[r]       = 1'b1;
        req_data[8*r +: 8] = src_mem[r][src_ptr[r]];
      end else begin
        req_valid[r]       = 1'b0;
        req_data[8*r +: 8] = 8'h00;
      end
    end
  endtask

  task automatic exp_grant(input int r);
    if (TAG_EN) exp_q.push_back(8'hF0 | 8'(r));
  endtask

  task automatic exp_b(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  function automatic int pending_bytes();
    int n = 0;
    for (int r = 0; r < NUM_REQ; r++) n += src_cnt[r] - src_ptr[r];
    return n;
  endfunction

  // One cycle: sample on the falling edge, update sources just after the rising edge.
  task automatic step();
    @(negedge clk_48mhz);
    s_busy   = busy;
    s_valid  = uart_in_valid;
    s_data   = uart_in_data;
    s_grant  = grant_idx;
    s_rdy    = req_ready;
    s_hs     = req_valid & req_ready;
    s_out_hs = uart_in_valid && uart_in_ready;
    if (s_out_hs) begin
      out_total++;
      if (exp_q.size() > 0) check_val("sb_data", {24'd0, s_data}, {24'd0, exp_q.pop_front()});
      else check_val("sb_unexpected", {24'd0, s_data}, 32'hFFFF_FFFF);
    end
    @(posedge clk_48mhz);
    #1;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (s_hs[r]) src_ptr[r]++;
    end
    drive_inputs();
  endtask

  task automatic run_until_idle(input string tag);
    int guard = 0;
    do begin
      step();
      guard++;
    end while ((exp_q.size() != 0 || s_busy || pending_bytes() != 0) && guard < 400);
    check_val({tag, "_drain"}, exp_q.size(), 0);
    check_val({tag, "_busy"}, {31'd0, s_busy}, 0);
    check_val({tag, "_pending"}, pending_bytes(), 0);
  endtask

  initial begin
    int guard;
    int lat;
    int hold;
    int base;
    logic [7:0] bp_hold;

    reset_n       = 1'b0;
    req_valid     = '0;
    req_data      = '0;
    uart_in_ready = 1'b1;
    src_clear();
    repeat (3) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    check_val("rst_valid", {31'd0, uart_in_valid}, 0);
    check_val("rst_data", {24'd0, uart_in_data}, 0);
    check_val("rst_req_ready", {28'd0, req_ready}, 0);
    check_val("rst_grant", {30'd0, grant_idx}, 0);
    check_val("rst_busy", {31'd0, busy}, 0);
    @(posedge clk_48mhz);
    #1 reset_n = 1'b1;

    // single stream from requester 2, with grant-to-data latency
    src_clear();
    src_add(2, 8'h41); src_add(2, 8'h42); src_add(2, 8'h0A);
    exp_grant(2); exp_b(8'h41); exp_b(8'h42); exp_b(8'h0A);
    drive_inputs();
    guard = 0;
    do begin step(); guard++; end while (!s_busy && guard < 20);
    check_val("t1_grant_idx", {30'd0, s_grant}, 2);
    lat = 0;
    do begin step(); lat++; end while (!(s_valid && s_data == 8'h41) && lat < 10);
    check_val("t1_latency", lat, TAG_EN ? 2 : 1);
    run_until_idle("t1");

    // contention: 0 and 1 together, pointer at 3 so 0 goes first, no interleave
    src_clear();
    src_add(0, 8'h10); src_add(0, 8'h11); src_add(0, 8'h0A);
    src_add(1, 8'h20); src_add(1, 8'h21); src_add(1, 8'h0A);
    exp_grant(0); exp_b(8'h10); exp_b(8'h11); exp_b(8'h0A);
    exp_grant(1); exp_b(8'h20); exp_b(8'h21); exp_b(8'h0A);
    drive_inputs();
    run_until_idle("t2");

    // pointer now 2: requester 3 beats requester 0
    src_clear();
    src_add(3, 8'h30); src_add(3, 8'h0A);
    src_add(0, 8'h12); src_add(0, 8'h0A);
    exp_grant(3); exp_b(8'h30); exp_b(8'h0A);
    exp_grant(0); exp_b(8'h12); exp_b(8'h0A);
    drive_inputs();
    run_until_idle("t3");

    // burst cap: 1 streams 10 bytes, 3 waits; last two bytes end by idle timeout
    src_clear();
    for (int i = 0; i < 10; i++) src_add(1, 8'h50 + 8'(i));
    src_add(3, 8'h60); src_add(3, 8'h61); src_add(3, 8'h0A);
    exp_grant(1);
    for (int i = 0; i < 4; i++) exp_b(8'h50 + 8'(i));
    exp_grant(3); exp_b(8'h60); exp_b(8'h61); exp_b(8'h0A);
    exp_grant(1);
    for (int i = 4; i < 8; i++) exp_b(8'h50 + 8'(i));
    exp_grant(1); exp_b(8'h58); exp_b(8'h59);
    drive_inputs();
    run_until_idle("t4");

    // backpressure: 5 stalled cycles mid-frame
    src_clear();
    src_add(2, 8'h70); src_add(2, 8'h71); src_add(2, 8'h72); src_add(2, 8'h0A);
    exp_grant(2); exp_b(8'h70); exp_b(8'h71); exp_b(8'h72); exp_b(8'h0A);
    drive_inputs();
    base = out_total;
    guard = 0;
    do begin step(); guard++; end while ((out_total - base) < 2 && guard < 20);
    uart_in_ready = 1'b0;
    bp_hold = TAG_EN ? 8'h71 : 8'h72;
    for (int k = 0; k < 5; k++) begin
      step();
      check_val("bp_valid", {31'd0, s_valid}, 1);
      check_val("bp_data", {24'd0, s_data}, {24'd0, bp_hold});
      check_val("bp_req_ready", {28'd0, s_rdy}, 0);
    end
    uart_in_ready = 1'b1;
    run_until_idle("t5");

    // idle timeout: requester 0 sends one byte then goes quiet; 2 is waiting
    src_clear();
    src_add(0, 8'h80);
    src_add(2, 8'h90); src_add(2, 8'h0A);
    exp_grant(0); exp_b(8'h80);
    exp_grant(2); exp_b(8'h90); exp_b(8'h0A);
    drive_inputs();
    guard = 0;
    do begin step(); guard++; end while (!s_hs[0] && guard < 20);
    hold = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!s_busy) break;
      hold++;
    end
    check_val("t6_idle_hold", hold, IDLE_TIMEOUT + 1);
    run_until_idle("t6");

    // asynchronous reset mid-frame
    src_clear();
    src_add(1, 8'hA0); src_add(1, 8'hA1); src_add(1, 8'hA2); src_add(1, 8'h0A);
    exp_grant(1); exp_b(8'hA0); exp_b(8'hA1); exp_b(8'hA2); exp_b(8'h0A);
    drive_inputs();
    base = out_total;
    guard = 0;
    do begin step(); guard++; end while ((out_total - base) < 1 && guard < 20);
    #2 reset_n = 1'b0;
    #1;
    check_val("rstm_valid", {31'd0, uart_in_valid}, 0);
    check_val("rstm_data", {24'd0, uart_in_data}, 0);
    check_val("rstm_req_ready", {28'd0, req_ready}, 0);
    check_val("rstm_busy", {31'd0, busy}, 0);
    check_val("rstm_grant", {30'd0, grant_idx}, 0);
    exp_q.delete();
    src_clear();
    drive_inputs();
    @(posedge clk_48mhz);
    #1 reset_n = 1'b1;

    // pointer back to 0; requester 1's frame hits TERM and MAX_BURST together
    src_clear();
    src_add(3, 8'hE0); src_add(3, 8'h0A);
    src_add(1, 8'hD0); src_add(1, 8'hD1); src_add(1, 8'hD2); src_add(1, 8'h0A);
    src_add(0, 8'hC0); src_add(0, 8'h0A);
    exp_grant(0); exp_b(8'hC0); exp_b(8'h0A);
    exp_grant(1); exp_b(8'hD0); exp_b(8'hD1); exp_b(8'hD2); exp_b(8'h0A);
    exp_grant(3); exp_b(8'hE0); exp_b(8'h0A);
    drive_inputs();
    run_until_idle("t8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
